aes_ctr_stream_arbiter: RTL and testbench

- Shares one AES-256-CTR streaming core between two AXI-Stream requesters, packet-atomically with round-robin fairness.
- A packet is 2 key beats (low half, then high half), 1 counter beat, then N≥1 text beats; tlast is set on the final text beat.
- The core returns exactly N output beats, tlast on the last one.
- The arbiter locks the grant from the first key beat until the core's final output beat is accepted, then routes that output back to the owning requester.

---
 rtl/aes_ctr_stream_arbiter.sv | 174 +++++++++++++++++
 tb/tb_aes_ctr_stream_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_stream_arbiter.sv
// Packet-atomic round-robin arbiter sharing one AES-256-CTR streaming core between two AXI-Stream requesters.
// Optional per-channel release counters are enabled with `define AES_ARB_STATS_EN.
module aes_ctr_stream_arbiter #(
    parameter int BLOCK_SIZE   = 128,
    parameter int HEADER_BEATS = 3
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    S0_axis_tvalid,
    output logic                    S0_axis_tready,
    input  logic [BLOCK_SIZE-1:0]   S0_axis_tdata,
    input  logic [BLOCK_SIZE/8-1:0] S0_axis_tkeep,
    input  logic                    S0_axis_tlast,
    input  logic                    S0_axis_tuser,
    input  logic                    S1_axis_tvalid,
    output logic                    S1_axis_tready,
    input  logic [BLOCK_SIZE-1:0]   S1_axis_tdata,
    input  logic [BLOCK_SIZE/8-1:0] S1_axis_tkeep,
    input  logic                    S1_axis_tlast,
    input  logic                    S1_axis_tuser,
    output logic                    C_axis_tvalid,
    input  logic                    C_axis_tready,
    output logic [BLOCK_SIZE-1:0]   C_axis_tdata,
    output logic [BLOCK_SIZE/8-1:0] C_axis_tkeep,
    output logic                    C_axis_tlast,
    output logic                    C_axis_tuser,
    input  logic                    R_axis_tvalid,
    output logic                    R_axis_tready,
    input  logic [BLOCK_SIZE-1:0]   R_axis_tdata,
    input  logic [BLOCK_SIZE/8-1:0] R_axis_tkeep,
    input  logic                    R_axis_tlast,
    output logic                    M0_axis_tvalid,
    input  logic                    M0_axis_tready,
    output logic [BLOCK_SIZE-1:0]   M0_axis_tdata,
    output logic [BLOCK_SIZE/8-1:0] M0_axis_tkeep,
    output logic                    M0_axis_tlast,
    output logic                    M1_axis_tvalid,
    input  logic                    M1_axis_tready,
    output logic [BLOCK_SIZE-1:0]   M1_axis_tdata,
    output logic [BLOCK_SIZE/8-1:0] M1_axis_tkeep,
    output logic                    M1_axis_tlast,
    output logic [1:0]              Grant
`ifdef AES_ARB_STATS_EN
    ,
    output logic [31:0]             Pkt_count0,
    output logic [31:0]             Pkt_count1
`endif
);

    localparam int CNT_W = $clog2(HEADER_BEATS + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_TEXT, ST_DRAIN} state_e;

    state_e             state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic owner, fwd, active, c_hs, r_hs, pkt_release;
    logic                    sel_tvalid, sel_tlast, sel_tuser;
    logic [BLOCK_SIZE-1:0]   sel_tdata;
    logic [BLOCK_SIZE/8-1:0] sel_tkeep;

    assign owner  = grant_q[1];
    assign fwd    = (state_q == ST_HEADER) || (state_q == ST_TEXT);
    assign active = (state_q != ST_IDLE);

    assign sel_tvalid = owner ? S1_axis_tvalid : S0_axis_tvalid;
    assign sel_tdata  = owner ? S1_axis_tdata  : S0_axis_tdata;
    assign sel_tkeep  = owner ? S1_axis_tkeep  : S0_axis_tkeep;
    assign sel_tlast  = owner ? S1_axis_tlast  : S0_axis_tlast;
    assign sel_tuser  = owner ? S1_axis_tuser  : S0_axis_tuser;

    // Every output is gated by state so that everything reads zero while idle or in reset.
    assign C_axis_tvalid  = fwd && sel_tvalid;
    assign C_axis_tdata   = fwd ? sel_tdata : '0;
    assign C_axis_tkeep   = fwd ? sel_tkeep : '0;
    assign C_axis_tlast   = fwd && sel_tlast;
    assign C_axis_tuser   = fwd && sel_tuser;
    assign S0_axis_tready = fwd && grant_q[0] && C_axis_tready;
    assign S1_axis_tready = fwd && grant_q[1] && C_axis_tready;

    assign R_axis_tready  = active && ((grant_q[0] && M0_axis_tready) || (grant_q[1] && M1_axis_tready));
    assign M0_axis_tvalid = active && grant_q[0] && R_axis_tvalid;
    assign M0_axis_tdata  = (active && grant_q[0]) ? R_axis_tdata : '0;
    assign M0_axis_tkeep  = (active && grant_q[0]) ? R_axis_tkeep : '0;
    assign M0_axis_tlast  = active && grant_q[0] && R_axis_tlast;
    assign M1_axis_tvalid = active && grant_q[1] && R_axis_tvalid;
    assign M1_axis_tdata  = (active && grant_q[1]) ? R_axis_tdata : '0;
    assign M1_axis_tkeep  = (active && grant_q[1]) ? R_axis_tkeep : '0;
    assign M1_axis_tlast  = active && grant_q[1] && R_axis_tlast;

    assign Grant = grant_q;

    assign c_hs = C_axis_tvalid && C_axis_tready;
    assign r_hs = R_axis_tvalid && R_axis_tready;
    // A final response beat frees the core even if the request side never sent its tlast.
    assign pkt_release = r_hs && R_axis_tlast && ((state_q == ST_TEXT) || (state_q == ST_DRAIN));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                beat_cnt_d = '0;
                if (S0_axis_tvalid && S1_axis_tvalid) begin
                    grant_d = last_grant_q ? 2'b01 : 2'b10;
                    state_d = ST_HEADER;
                end else if (S0_axis_tvalid) begin
                    grant_d = 2'b01;
                    state_d = ST_HEADER;
                end else if (S1_axis_tvalid) begin
                    grant_d = 2'b10;
                    state_d = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (c_hs) begin
                    if (beat_cnt_q == CNT_W'(HEADER_BEATS - 1)) begin
                        beat_cnt_d = '0;
                        state_d    = ST_TEXT;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_TEXT: begin
                if (c_hs && sel_tlast) state_d = ST_DRAIN;
            end
            default: ;
        endcase
        if (pkt_release) begin
            state_d      = ST_IDLE;
            grant_d      = 2'b00;
            last_grant_d = owner;
        end
    end

`ifdef AES_ARB_STATS_EN
    logic [31:0] pkt_count0_q, pkt_count1_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pkt_count0_q <= '0;
            pkt_count1_q <= '0;
        end else if (pkt_release) begin
            if (owner) pkt_count1_q <= pkt_count1_q + 32'd1;
            else       pkt_count0_q <= pkt_count0_q + 32'd1;
        end
    end

    assign Pkt_count0 = pkt_count0_q;
    assign Pkt_count1 = pkt_count1_q;
`endif

endmodule

// File: tb/tb_aes_ctr_stream_arbiter.sv
// Scoreboard bench for aes_ctr_stream_arbiter: the bench plays both requesters, the core and both sinks.
module tb_aes_ctr_stream_arbiter;

    localparam int BW = 128;
    localparam int KW = BW / 8;

    typedef struct packed {
        logic [BW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic          s_tvalid [2], s_tready [2], s_tlast [2], s_tuser [2];
    logic [BW-1:0] s_tdata  [2];
    logic [KW-1:0] s_tkeep  [2];
    logic          c_tvalid, c_tready, c_tlast, c_tuser;
    logic [BW-1:0] c_tdata;
    logic [KW-1:0] c_tkeep;
    logic          r_tvalid, r_tready, r_tlast;
    logic [BW-1:0] r_tdata;
    logic [KW-1:0] r_tkeep;
    logic          m_tvalid [2], m_tready [2], m_tlast [2];
    logic [BW-1:0] m_tdata  [2];
    logic [KW-1:0] m_tkeep  [2];
    logic [1:0]    grant;
`ifdef AES_ARB_STATS_EN
    logic [31:0]   pkt_count0, pkt_count1;
`endif

    aes_ctr_stream_arbiter dut (
        .Clk(clk), .Rst(rst),
        .S0_axis_tvalid(s_tvalid[0]), .S0_axis_tready(s_tready[0]), .S0_axis_tdata(s_tdata[0]),
        .S0_axis_tkeep(s_tkeep[0]), .S0_axis_tlast(s_tlast[0]), .S0_axis_tuser(s_tuser[0]),
        .S1_axis_tvalid(s_tvalid[1]), .S1_axis_tready(s_tready[1]), .S1_axis_tdata(s_tdata[1]),
        .S1_axis_tkeep(s_tkeep[1]), .S1_axis_tlast(s_tlast[1]), .S1_axis_tuser(s_tuser[1]),
        .C_axis_tvalid(c_tvalid), .C_axis_tready(c_tready), .C_axis_tdata(c_tdata),
        .C_axis_tkeep(c_tkeep), .C_axis_tlast(c_tlast), .C_axis_tuser(c_tuser),
        .R_axis_tvalid(r_tvalid), .R_axis_tready(r_tready), .R_axis_tdata(r_tdata),
        .R_axis_tkeep(r_tkeep), .R_axis_tlast(r_tlast),
        .M0_axis_tvalid(m_tvalid[0]), .M0_axis_tready(m_tready[0]), .M0_axis_tdata(m_tdata[0]),
        .M0_axis_tkeep(m_tkeep[0]), .M0_axis_tlast(m_tlast[0]),
        .M1_axis_tvalid(m_tvalid[1]), .M1_axis_tready(m_tready[1]), .M1_axis_tdata(m_tdata[1]),
        .M1_axis_tkeep(m_tkeep[1]), .M1_axis_tlast(m_tlast[1]),
        .Grant(grant)
`ifdef AES_ARB_STATS_EN
        , .Pkt_count0(pkt_count0), .Pkt_count1(pkt_count1)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    beat_t      src_q   [2][$];
    beat_t      exp_c_q [2][$];
    beat_t      exp_m_q [2][$];
    beat_t      core_q  [$];
    int         owner_log [$];
    logic [1:0] glog [$];
    logic [1:0] run_v [$];
    int         run_l [$];

    bit  s_acc [2];
    bit  r_acc;
    bit  rand_en;
    bit  glog_en;
    bit  m_hold [2];
    int  m_seen [2];
    int  m_hs_cnt [2];
    int  rel_cnt [2];
    int  issued_cnt [2];
    int  c_hs_cnt;
    int  core_idx;
    logic [BW-1:0] k_lo, k_hi, ctr_v;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Stand-in keystream for the core: any deterministic function of key, counter and block index will do.
    function automatic logic [BW-1:0] keystream(input logic [BW-1:0] kl, input logic [BW-1:0] kh,
                                                input logic [BW-1:0] ct, input int idx);
        return kl ^ {kh[63:0], kh[127:64]} ^ (ct + BW'(idx));
    endfunction

    task automatic gen_pkt(input int ch, input int ntext, input bit complete, input bit hdr_last_rand);
        beat_t b, o;
        logic [BW-1:0] kl, kh, ct;
        kl = rand128(); kh = rand128(); ct = rand128();
        for (int i = 0; i < 3; i++) begin
            b.data = (i == 0) ? kl : (i == 1) ? kh : ct;
            b.keep = '1;
            b.last = hdr_last_rand ? 1'($urandom_range(0, 1)) : 1'b0;
            b.user = 1'($urandom_range(0, 1));
            src_q[ch].push_back(b);
            exp_c_q[ch].push_back(b);
        end
        for (int i = 0; i < ntext; i++) begin
            b.data = rand128();
            b.keep = KW'($urandom);
            b.last = complete && (i == ntext - 1);
            b.user = 1'($urandom_range(0, 1));
            src_q[ch].push_back(b);
            exp_c_q[ch].push_back(b);
            o.data = b.data ^ keystream(kl, kh, ct, i);
            o.keep = b.keep;
            o.last = b.last;
            o.user = 1'b0;
            exp_m_q[ch].push_back(o);
        end
        if (complete) issued_cnt[ch]++;
    endtask

    task automatic clear_tb();
        for (int ch = 0; ch < 2; ch++) begin
            src_q[ch].delete(); exp_c_q[ch].delete(); exp_m_q[ch].delete();
            s_acc[ch] = 0; rel_cnt[ch] = 0; issued_cnt[ch] = 0;
        end
        core_q.delete();
        r_acc = 0;
        core_idx = 0;
    endtask

    task automatic sync_reset();
        @(negedge clk); #2;
        rst = 1'b1;
        clear_tb();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    function automatic bit all_empty();
        return src_q[0].size() == 0 && src_q[1].size() == 0 && exp_c_q[0].size() == 0 &&
               exp_c_q[1].size() == 0 && exp_m_q[0].size() == 0 && exp_m_q[1].size() == 0 &&
               core_q.size() == 0;
    endfunction

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (n < budget && !(all_empty() && grant == 2'b00)) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, n < budget, 1'b1);
    endtask

    task automatic compress_glog();
        run_v.delete(); run_l.delete();
        foreach (glog[i]) begin
            if (run_v.size() == 0 || run_v[run_v.size()-1] != glog[i]) begin
                run_v.push_back(glog[i]);
                run_l.push_back(1);
            end else begin
                run_l[run_l.size()-1] = run_l[run_l.size()-1] + 1;
            end
        end
    endtask

    // Driver: all inputs change 1 time unit after the rising edge.
    initial begin : drv
        beat_t b;
        for (int ch = 0; ch < 2; ch++) begin
            s_tvalid[ch] = 0; s_tdata[ch] = '0; s_tkeep[ch] = '0; s_tlast[ch] = 0; s_tuser[ch] = 0;
            m_tready[ch] = 0;
        end
        r_tvalid = 0; r_tdata = '0; r_tkeep = '0; r_tlast = 0; c_tready = 0;
        forever begin
            @(posedge clk); #1;
            for (int ch = 0; ch < 2; ch++) begin
                if (s_acc[ch] && src_q[ch].size() > 0) src_q[ch].delete(0);
                s_acc[ch] = 0;
                if (src_q[ch].size() > 0 && (!rand_en || $urandom_range(0, 3) != 0)) begin
                    b = src_q[ch][0];
                    s_tvalid[ch] = 1; s_tdata[ch] = b.data; s_tkeep[ch] = b.keep;
                    s_tlast[ch] = b.last; s_tuser[ch] = b.user;
                end else begin
                    s_tvalid[ch] = 0;
                end
                m_tready[ch] = !m_hold[ch] && (!rand_en || $urandom_range(0, 3) != 0);
            end
            if (r_acc && core_q.size() > 0) core_q.delete(0);
            r_acc = 0;
            if (core_q.size() > 0 && (!rand_en || $urandom_range(0, 3) != 0)) begin
                b = core_q[0];
                r_tvalid = 1; r_tdata = b.data; r_tkeep = b.keep; r_tlast = b.last;
            end else begin
                r_tvalid = 0;
            end
            c_tready = !rand_en || $urandom_range(0, 3) != 0;
        end
    end

    // Monitor and core model: everything is sampled on the falling edge.
    initial begin : mon
        beat_t e, o;
        int owner;
        forever begin
            @(negedge clk);
            if (glog_en) glog.push_back(grant);
            if (rst) continue;
            if (c_tvalid && c_tready) begin
                c_hs_cnt++;
                owner = int'(grant[1]);
                check("c_grant_onehot", (grant == 2'b01) || (grant == 2'b10), 1'b1);
                check("c_has_expected", exp_c_q[owner].size() != 0, 1'b1);
                if (exp_c_q[owner].size() != 0) begin
                    e = exp_c_q[owner].pop_front();
                    check("c_beat", {c_tdata, c_tkeep, c_tlast, c_tuser}, e);
                end
                if (core_idx == 0) owner_log.push_back(owner);
                if (core_idx == 0) k_lo = c_tdata;
                else if (core_idx == 1) k_hi = c_tdata;
                else if (core_idx == 2) ctr_v = c_tdata;
                else begin
                    o.data = c_tdata ^ keystream(k_lo, k_hi, ctr_v, core_idx - 3);
                    o.keep = c_tkeep; o.last = c_tlast; o.user = 1'b0;
                    core_q.push_back(o);
                end
                core_idx = (core_idx >= 3 && c_tlast) ? 0 : core_idx + 1;
            end
            for (int ch = 0; ch < 2; ch++) begin
                s_acc[ch] = s_tvalid[ch] && s_tready[ch];
                if (!grant[ch]) begin
                    check("s_tready_not_granted", s_tready[ch], 1'b0);
                    check("m_quiet_not_granted", {m_tvalid[ch], m_tdata[ch]}, '0);
                end
                if (m_tvalid[ch]) m_seen[ch]++;
                if (m_tvalid[ch] && m_tready[ch]) begin
                    m_hs_cnt[ch]++;
                    check("m_has_expected", exp_m_q[ch].size() != 0, 1'b1);
                    if (exp_m_q[ch].size() != 0) begin
                        e = exp_m_q[ch].pop_front();
                        check("m_beat", {m_tdata[ch], m_tkeep[ch], m_tlast[ch]}, {e.data, e.keep, e.last});
                    end
                    if (m_tlast[ch]) rel_cnt[ch]++;
                end
            end
            if (grant == 2'b00) check("r_tready_idle", r_tready, 1'b0);
            r_acc = r_tvalid && r_tready;
        end
    end

    initial begin : watchdog
        #500000;
        n_fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin : main
        int n, base;
        logic [BW-1:0] snap;
        rand_en = 0; glog_en = 0;
        m_hold[0] = 0; m_hold[1] = 0;
        m_seen[0] = 0; m_seen[1] = 0; m_hs_cnt[0] = 0; m_hs_cnt[1] = 0;
        c_hs_cnt = 0;
        rst = 1'b1;
        clear_tb();
        repeat (3) @(negedge clk);
        check("rst_outputs", {grant, c_tvalid, c_tdata, s_tready[0], s_tready[1],
                              m_tvalid[0], m_tvalid[1], r_tready}, '0);
        #2 rst = 1'b0;

        // Single ch0 packet, everything ready.
        glog.delete(); glog_en = 1; c_hs_cnt = 0;
        gen_pkt(0, 2, 1, 0);
        wait_done("p1", 200);
        repeat (2) @(negedge clk);
        glog_en = 0;
        compress_glog();
        check("p1_grant_runs", run_v.size(), 3);
        if (run_v.size() == 3) check("p1_grant_seq", {run_v[0], run_v[1], run_v[2]}, 6'b00_01_00);
        check("p1_m1_quiet", m_seen[1], 0);
        check("p1_m0_beats", m_hs_cnt[0], 2);
        check("p1_c_beats", c_hs_cnt, 5);

        // Simultaneous requests after reset: ch0 first, one idle cycle, then ch1.
        sync_reset();
        owner_log.delete(); glog.delete(); glog_en = 1;
        gen_pkt(0, 1, 1, 0);
        gen_pkt(1, 1, 1, 0);
        wait_done("p2", 300);
        @(negedge clk);
        glog_en = 0;
        compress_glog();
        check("p2_grant_runs", run_v.size(), 5);
        if (run_v.size() == 5) begin
            check("p2_grant_seq", {run_v[0], run_v[1], run_v[2], run_v[3], run_v[4]}, 10'b00_01_00_10_00);
            check("p2_idle_gap", run_l[2], 1);
        end
        check("p2_owner_cnt", owner_log.size(), 2);
        if (owner_log.size() == 2) check("p2_owner_order", {owner_log[0][0], owner_log[1][0]}, 2'b01);

        // Both requesters continuously valid: grants alternate.
        owner_log.delete();
        for (int i = 0; i < 3; i++) begin
            gen_pkt(0, $urandom_range(1, 3), 1, 0);
            gen_pkt(1, $urandom_range(1, 3), 1, 0);
        end
        wait_done("p3", 1000);
        check("p3_owner_cnt", owner_log.size(), 6);
        foreach (owner_log[i]) check("p3_alternate", owner_log[i], i % 2);

        // M0 backpressure mid-response while ch1 waits with a partial packet queued.
        base = m_hs_cnt[0];
        gen_pkt(0, 4, 1, 0);
        gen_pkt(1, 2, 0, 0);
        n = 0;
        while (m_hs_cnt[0] == base && n < 200) begin @(negedge clk); n++; end
        check("p4_first_resp", n < 200, 1'b1);
        #1 m_hold[0] = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) snap = m_tdata[0];
            else check("p4_data_stable", m_tdata[0], snap);
            check("p4_r_tready_low", r_tready, 1'b0);
            check("p4_m0_valid", m_tvalid[0], 1'b1);
            check("p4_grant", grant, 2'b01);
            check("p4_s1_blocked", s_tready[1], 1'b0);
        end
        #1 m_hold[0] = 0;
        n = 0;
        while (n < 300 && !(src_q[1].size() == 0 && exp_m_q[1].size() == 0 && exp_m_q[0].size() == 0)) begin
            @(negedge clk); n++;
        end
        check("p4_partial_timeout", n < 300, 1'b1);
        repeat (3) @(negedge clk);
        check("p4_ch1_holds", grant, 2'b10);

        // Asynchronous reset between edges with ch1 stuck mid-text.
        #3 rst = 1'b1;
        clear_tb();
        #1;
        check("p5_rst_grant", grant, 2'b00);
        check("p5_rst_c", {c_tvalid, c_tdata, c_tkeep, c_tlast, c_tuser}, '0);
        check("p5_rst_ready", {s_tready[0], s_tready[1], r_tready}, 3'b000);
        check("p5_rst_m", {m_tvalid[1], m_tdata[1], m_tlast[1]}, '0);
        @(negedge clk); #2 rst = 1'b0;
        owner_log.delete();
        gen_pkt(1, 3, 1, 0);
        wait_done("p5", 300);
        check("p5_owner_cnt", owner_log.size(), 1);
        if (owner_log.size() == 1) check("p5_owner", owner_log[0], 1);
        check("p5_released", rel_cnt[1], 1);

        // Randomised traffic, bubbles, backpressure and stray header tlast.
        rand_en = 1;
        for (int i = 0; i < 14; i++) begin
            gen_pkt(int'($urandom_range(0, 1)), $urandom_range(1, 5), 1, 1);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        wait_done("p6", 8000);
        check("p6_rel_ch0", rel_cnt[0], issued_cnt[0]);
        check("p6_rel_ch1", rel_cnt[1], issued_cnt[1]);
        rand_en = 0;

`ifdef AES_ARB_STATS_EN
        check("p7_count0", pkt_count0, rel_cnt[0]);
        check("p7_count1", pkt_count1, rel_cnt[1]);
        @(negedge clk);
        force dut.pkt_count0_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.pkt_count0_q;
        gen_pkt(0, 1, 1, 0);
        wait_done("p7", 300);
        check("p7_wrap", pkt_count0, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
